uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames with 16x oversampling, the receive end of the team's UART link. It takes the asynchronous line `rx_in`, synchronises it into the `clk` domain, and validates the start bit at mid-bit. It samples 8 data bits LSB-first and checks the stop bit, then presents the byte on `RX_BYTE` with a one-cycle `RX_VALID` strobe. Bit timing comes from an external baud generator that supplies a single-cycle `rx_tick` enable at 16x the baud rate.

---
 rtl/uart_receiver_if.sv | 37 +++
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Port bundle for uart_receiver: serial line and tick in, received byte out.
// RX_PARITY_ERR exists only when RX_PARITY_EN is defined.
interface uart_receiver_if;
    logic       rx_tick;
    logic       rx_in;
    logic [7:0] RX_BYTE;
    logic       RX_VALID;
    logic       RX_BUSY;
    logic       RX_FRAME_ERR;
`ifdef RX_PARITY_EN
    logic       RX_PARITY_ERR;
`endif

    modport master (
        input  rx_tick,
        input  rx_in,
`ifdef RX_PARITY_EN
        output RX_PARITY_ERR,
`endif
        output RX_BYTE,
        output RX_VALID,
        output RX_BUSY,
        output RX_FRAME_ERR
    );

    modport slave (
        output rx_tick,
        output rx_in,
`ifdef RX_PARITY_EN
        input  RX_PARITY_ERR,
`endif
        input  RX_BYTE,
        input  RX_VALID,
        input  RX_BUSY,
        input  RX_FRAME_ERR
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and mid-bit start validation.
// Define RX_PARITY_EN for an even-parity bit between data and stop.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master bus
);
    localparam logic [3:0] HALF_M1 = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] FULL_M1 = 4'(OVERSAMPLE - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic       rx_m, rx_s, rx_prev;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
`ifdef RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_m    <= bus.rx_in;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Edge detect runs every clk so a held-low line never retriggers
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (bus.rx_tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == HALF_M1) begin
                        state_d = rx_s ? IDLE : DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (bus.rx_tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
`ifdef RX_PARITY_EN
                        if (bit_q == 3'd7) state_d = PARITY;
`else
                        if (bit_q == 3'd7) state_d = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bus.rx_tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == FULL_M1) begin
                        par_d   = rx_s;
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.rx_tick) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == FULL_M1) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                        end
`ifdef RX_PARITY_EN
                        perr_d = (^shift_q) ^ par_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    assign bus.RX_BYTE      = byte_q;
    assign bus.RX_VALID     = valid_q;
    assign bus.RX_BUSY      = (state_q != IDLE);
    assign bus.RX_FRAME_ERR = ferr_q;
`ifdef RX_PARITY_EN
    assign bus.RX_PARITY_ERR = perr_q;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: vector table of frames plus
// hand sequences for break, back-to-back, glitch and mid-frame reset.
module tb_uart_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] tick_ph = 2'd0;

    uart_receiver_if bus();

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One tick every 4 clk, so a bit period is 64 clk
    always @(posedge clk) tick_ph <= tick_ph + 2'd1;
    assign bus.rx_tick = (tick_ph == 2'd0);

    int checks = 0;
    int errors = 0;

    int v_cnt = 0;
    int f_cnt = 0;
    int p_cnt = 0;
    int busy_at_v = 0;
    int nb = 0;
    logic [7:0] got [64];

    always @(negedge clk) begin
        if (bus.RX_VALID) begin
            v_cnt <= v_cnt + 1;
            got[nb % 64] <= bus.RX_BYTE;
            nb <= nb + 1;
            if (bus.RX_BUSY) busy_at_v <= busy_at_v + 1;
        end
        if (bus.RX_FRAME_ERR) f_cnt <= f_cnt + 1;
`ifdef RX_PARITY_EN
        if (bus.RX_PARITY_ERR) p_cnt <= p_cnt + 1;
`endif
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.rx_in = b;
        repeat (63) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit((^d) ^ pflip);
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int v0, f0, p0, n0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 1, 0, 8'h80};

        bus.rx_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_byte", int'(bus.RX_BYTE), 0);
        check("reset_valid", int'(bus.RX_VALID), 0);
        check("reset_busy", int'(bus.RX_BUSY), 0);
        check("reset_ferr", int'(bus.RX_FRAME_ERR), 0);
`ifdef RX_PARITY_EN
        check("reset_perr", int'(bus.RX_PARITY_ERR), 0);
`endif
        rst = 1'b0;
        idle(20);

        for (int k = 0; k < 4; k++) begin
            v0 = v_cnt; f0 = f_cnt; p0 = p_cnt;
            send_frame(vecs[k].data, vecs[k].stop, 1'b0);
            idle(64);
            check($sformatf("vec%0d_valid", k), v_cnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k), f_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_byte", k), int'(bus.RX_BYTE),
                  int'(vecs[k].exp_byte));
            check($sformatf("vec%0d_busy", k), int'(bus.RX_BUSY), 0);
`ifdef RX_PARITY_EN
            check($sformatf("vec%0d_perr", k), p_cnt - p0, 0);
`endif
        end
        check("busy_at_valid", busy_at_v, 0);

        // Framing error then held-low break
        v0 = v_cnt; f0 = f_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (256) @(negedge clk);
        check("break_valid", v_cnt - v0, 0);
        check("break_ferr", f_cnt - f0, 1);
        check("break_busy", int'(bus.RX_BUSY), 0);
        check("break_byte", int'(bus.RX_BYTE), 8'h80);
        idle(64);
        v0 = v_cnt;
        send_frame(8'h96, 1'b1, 1'b0);
        idle(64);
        check("after_break_valid", v_cnt - v0, 1);
        check("after_break_byte", int'(bus.RX_BYTE), 8'h96);

        // Back-to-back frames, no gap
        n0 = nb;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(64);
        check("b2b_count", nb - n0, 2);
        check("b2b_first", int'(got[n0 % 64]), 8'h00);
        check("b2b_second", int'(got[(n0 + 1) % 64]), 8'hFF);

        // 4-tick glitch
        v0 = v_cnt; f0 = f_cnt;
        @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (16) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy_mid", int'(bus.RX_BUSY), 1);
        repeat (100) @(negedge clk);
        check("glitch_busy", int'(bus.RX_BUSY), 0);
        check("glitch_strobes", (v_cnt - v0) + (f_cnt - f0), 0);

        // Reset during data bit 4 of 0x81
        v0 = v_cnt; f0 = f_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
        @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_busy_before", int'(bus.RX_BUSY), 1);
        rst = 1'b1;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(bus.RX_BUSY), 0);
        check("midrst_byte", int'(bus.RX_BYTE), 0);
        repeat (700) @(negedge clk);
        check("midrst_strobes", (v_cnt - v0) + (f_cnt - f0), 0);
        v0 = v_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(64);
        check("post_rst_valid", v_cnt - v0, 1);
        check("post_rst_byte", int'(bus.RX_BYTE), 8'h5A);

`ifdef RX_PARITY_EN
        v0 = v_cnt; p0 = p_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(64);
        check("par_ok_valid", v_cnt - v0, 1);
        check("par_ok_perr", p_cnt - p0, 0);
        v0 = v_cnt; p0 = p_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(64);
        check("par_bad_valid", v_cnt - v0, 1);
        check("par_bad_perr", p_cnt - p0, 1);
        check("par_bad_byte", int'(bus.RX_BYTE), 8'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
